// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences RV32M multiplies through an external unsigned 32x32
// array multiplier. It converts operands to magnitudes, waits out the
// multicycle multiplier path and sign-corrects the 64-bit product. A
// one-entry product cache serves repeated operand pairs without a multiply.
module mul_ctrl #(
  parameter int MUL_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  funct_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_p_i
);

  typedef enum logic [1:0] {IDLE, MULT, FIX, DONE} state_t;

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;
  localparam logic [1:0] CNT_INIT = 2'(MUL_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  funct_q;
  logic [31:0] a_q, b_q;
  logic        neg_q;
  logic [1:0]  cnt;
  logic [63:0] p_q;

  logic        cache_valid;
  logic [31:0] cache_a, cache_b;
  logic [1:0]  cache_funct;
  logic [63:0] cache_prod;

  logic        a_signed, b_signed, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        accept, cache_hit;
  logic [63:0] prod_fix;

  // Operand sign handling, handshake decode, cache lookup and sign correction
  always_comb begin
    a_signed  = (funct_i == F_MULH) || (funct_i == F_MULHSU);
    b_signed  = (funct_i == F_MULH);
    sa        = operand_a_i[31] & a_signed;
    sb        = operand_b_i[31] & b_signed;
    mag_a     = sa ? (~operand_a_i + 32'd1) : operand_a_i;
    mag_b     = sb ? (~operand_b_i + 32'd1) : operand_b_i;
    accept    = req_valid_i && req_ready_o;
    cache_hit = cache_valid && (operand_a_i == cache_a) && (operand_b_i == cache_b) &&
                ((funct_i == F_MUL) || (funct_i == cache_funct));
    prod_fix  = neg_q ? (~p_q + 64'd1) : p_q;
  end

  // Handshake outputs derive directly from the registered state
  always_comb begin
    req_ready_o  = (state == IDLE) && !flush_i;
    resp_valid_o = (state == DONE);
    busy_o       = (state != IDLE);
  end

  // Next-state logic; flush overrides every handshake
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = cache_hit ? DONE : MULT;
        MULT:    if (cnt == 2'd0) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    if (resp_ready_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: operand latch, multiplier wait, product capture, fix-up and cache
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      funct_q     <= 2'b00;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      neg_q       <= 1'b0;
      cnt         <= 2'd0;
      p_q         <= 64'd0;
      result_o    <= 32'd0;
      mul_a_o     <= 32'd0;
      mul_b_o     <= 32'd0;
      cache_valid <= 1'b0;
      cache_a     <= 32'd0;
      cache_b     <= 32'd0;
      cache_funct <= 2'b00;
      cache_prod  <= 64'd0;
    end else if (!flush_i) begin
      case (state)
        IDLE: begin
          if (accept) begin
            funct_q <= funct_i;
            a_q     <= operand_a_i;
            b_q     <= operand_b_i;
            neg_q   <= sa ^ sb;
            mul_a_o <= mag_a;
            mul_b_o <= mag_b;
            cnt     <= CNT_INIT;
            if (cache_hit)
              result_o <= (funct_i == F_MUL) ? cache_prod[31:0] : cache_prod[63:32];
          end
        end
        MULT: begin
          if (cnt == 2'd0) p_q <= mul_p_i;
          else             cnt <= cnt - 2'd1;
        end
        FIX: begin
          result_o    <= (funct_q == F_MUL) ? prod_fix[31:0] : prod_fix[63:32];
          cache_prod  <= prod_fix;
          cache_a     <= a_q;
          cache_b     <= b_q;
          cache_funct <= funct_q;
          cache_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: self-checking bench for mul_ctrl with a behavioural
// arithmetic reference and a model of the one-entry product cache.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  funct = 2'b00;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [31:0] result, mul_a, mul_b;
  logic        busy;
  logic [63:0] mul_p;

  logic        req_valid3 = 1'b0, req_ready3;
  logic [1:0]  funct3 = 2'b00;
  logic [31:0] op_a3 = 32'd0, op_b3 = 32'd0;
  logic        resp_valid3, busy3;
  logic [31:0] result3, mul_a3, mul_b3;
  logic [63:0] mul_p3, true_p3;
  int          edges3 = 15;

  int errors = 0;
  int checks = 0;

  bit          m_valid = 1'b0;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_f;

  always #5 clk = ~clk;

  assign mul_p   = {32'd0, mul_a} * {32'd0, mul_b};
  assign true_p3 = {32'd0, mul_a3} * {32'd0, mul_b3};
  // The slow multiplier only shows the right product in the last cycle before capture
  assign mul_p3  = (edges3 >= 2) ? true_p3 : ~true_p3;

  always @(posedge clk) begin
    if (req_valid3 && req_ready3) edges3 <= 0;
    else if (edges3 < 15)         edges3 <= edges3 + 1;
  end

  mul_ctrl #(.MUL_CYCLES(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .funct_i(funct), .operand_a_i(op_a), .operand_b_i(op_b), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .result_o(result),
    .busy_o(busy), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_i(mul_p)
  );

  mul_ctrl #(.MUL_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
    .funct_i(funct3), .operand_a_i(op_a3), .operand_b_i(op_b3), .flush_i(1'b0),
    .resp_valid_o(resp_valid3), .resp_ready_i(1'b1), .result_o(result3),
    .busy_o(busy3), .mul_a_o(mul_a3), .mul_b_o(mul_b3), .mul_p_i(mul_p3)
  );

  // Reference result straight from RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_mag(input bit is_signed, input logic [31:0] x);
    return (is_signed && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic bit predict_hit(input logic [1:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    return m_valid && a == m_a && b == m_b && (f == 2'd0 || f == m_f);
  endfunction

  task automatic model_fill(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    m_valid = 1'b1; m_a = a; m_b = b; m_f = f;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issues one request with resp_ready high and reports what the DUT did
  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       output bit acc, output logic [31:0] res, output int done_edge,
                       output logic [31:0] ma, output logic [31:0] mb);
    @(negedge clk);
    funct = f; op_a = a; op_b = b; resp_ready = 1'b1; req_valid = 1'b1;
    #1 acc = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    ma = mul_a; mb = mul_b;
    done_edge = 0;
    while (!resp_valid && done_edge < 20) begin
      @(negedge clk);
      done_edge++;
    end
    if (!resp_valid) done_edge = -1;
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", result); end
    checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_mul_ops: got %h %h want 0 0", mul_a, mul_b); end
  endtask

  task automatic test_directed();
    bit acc; logic [31:0] res, ma, mb; int de;
    do_op(2'd0, 32'd7, 32'hFFFF_FFFD, acc, res, de, ma, mb);
    model_fill(2'd0, 32'd7, 32'hFFFF_FFFD);
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL mul_accept: got %b want 1", acc); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mul_neg_result: got %h want ffffffeb", res); end
    checks++; if (de != 2) begin errors++; $display("[TB] FAIL mul_latency: got %0d want 2", de); end
    checks++; if (ma !== 32'd7) begin errors++; $display("[TB] FAIL mul_a_mag: got %h want 7", ma); end

    do_op(2'd1, 32'h8000_0000, 32'h8000_0000, acc, res, de, ma, mb);
    model_fill(2'd1, 32'h8000_0000, 32'h8000_0000);
    checks++; if (ma !== 32'h8000_0000 || mb !== 32'h8000_0000) begin errors++; $display("[TB] FAIL mulh_min_mags: got %h %h want 80000000 80000000", ma, mb); end
    checks++; if (res !== 32'h4000_0000) begin errors++; $display("[TB] FAIL mulh_min_result: got %h want 40000000", res); end

    do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc, res, de, ma, mb);
    model_fill(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mulhsu_result: got %h want ffffffff", res); end
    checks++; if (ma !== 32'd1 || mb !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mulhsu_mags: got %h %h want 1 ffffffff", ma, mb); end
  endtask

  task automatic test_cache();
    bit acc; logic [31:0] res, ma, mb; int de;
    do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc, res, de, ma, mb);
    model_fill(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (res !== 32'hFFFF_FFFE || de != 2) begin errors++; $display("[TB] FAIL mulhu_miss: got %h/%0d want fffffffe/2", res, de); end

    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc, res, de, ma, mb);
    checks++; if (res !== 32'd1) begin errors++; $display("[TB] FAIL mul_hit_result: got %h want 1", res); end
    checks++; if (de != 0) begin errors++; $display("[TB] FAIL mul_hit_latency: got %0d want 0", de); end
    checks++; if (ma !== 32'hFFFF_FFFF || mb !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mul_hit_ops: got %h %h want ffffffff ffffffff", ma, mb); end

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc, res, de, ma, mb);
    model_fill(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (res !== 32'd0 || de != 2) begin errors++; $display("[TB] FAIL mulh_after_mulhu: got %h/%0d want 0/2", res, de); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held; int k; bit hit; bit ok;
    hit = predict_hit(2'd0, 32'h1234, 32'h10);
    @(negedge clk);
    funct = 2'd0; op_a = 32'h1234; op_b = 32'h10; resp_ready = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 20) begin @(negedge clk); k++; end
    if (!hit) model_fill(2'd0, 32'h1234, 32'h10);
    held = result;
    checks++; if (held !== 32'h0001_2340) begin errors++; $display("[TB] FAIL bp_result: got %h want 00012340", held); end
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || result !== held || req_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_hold: got valid=%b ready=%b busy=%b want 1 0 1", resp_valid, req_ready, busy); end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got valid=%b ready=%b busy=%b want 0 1 0", resp_valid, req_ready, busy); end
  endtask

  task automatic test_flush();
    bit acc, ok; logic [31:0] res, ma, mb; int de;
    @(negedge clk);
    funct = 2'd0; op_a = 32'h55; op_b = 32'h77; resp_ready = 1'b1; req_valid = 1'b1; flush = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_ready: got %b want 0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_accept: got busy=%b want 0", busy); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_mult: got busy=%b valid=%b want 1 0", busy, resp_valid); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got ready=%b busy=%b want 1 0", req_ready, busy); end
    ok = 1'b1;
    repeat (4) begin @(negedge clk); if (resp_valid !== 1'b0) ok = 1'b0; end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL flush_no_resp: got resp_valid=1 want 0"); end
    do_op(2'd0, 32'h55, 32'h77, acc, res, de, ma, mb);
    model_fill(2'd0, 32'h55, 32'h77);
    checks++; if (res !== 32'h0000_2783 || de != 2) begin errors++; $display("[TB] FAIL flush_then_miss: got %h/%0d want 00002783/2", res, de); end
  endtask

  task automatic test_reset_mid();
    bit acc; logic [31:0] res, ma, mb; int de;
    @(negedge clk);
    funct = 2'd3; op_a = 32'hDEAD_0001; op_b = 32'h0000_1234; resp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_pre_fix: got busy=%b valid=%b want 1 0", busy, resp_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ctrl: got valid=%b busy=%b ready=%b want 0 0 1", resp_valid, busy, req_ready); end
    checks++; if (result !== 32'd0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_data: got %h %h %h want 0 0 0", result, mul_a, mul_b); end
    do_op(2'd0, 32'h55, 32'h77, acc, res, de, ma, mb);
    model_fill(2'd0, 32'h55, 32'h77);
    checks++; if (res !== 32'h0000_2783 || de != 2) begin errors++; $display("[TB] FAIL rst_clears_cache: got %h/%0d want 00002783/2", res, de); end
  endtask

  task automatic test_random();
    bit acc, hit; logic [31:0] res, ma, mb, a, b; logic [1:0] f; int de, bad;
    a = 32'd3; b = 32'd5;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin a = pick_operand(); b = pick_operand(); end
      f = 2'($urandom_range(0, 3));
      hit = predict_hit(f, a, b);
      do_op(f, a, b, acc, res, de, ma, mb);
      if (!hit) model_fill(f, a, b);
      checks++;
      if (res !== ref_result(f, a, b) || de != (hit ? 0 : 2) || acc !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand_op%0d f=%0d a=%h b=%h: got %h/%0d want %h/%0d", i, f, a, b,
                 res, de, ref_result(f, a, b), hit ? 0 : 2);
      end
      if (!hit) begin
        checks++;
        if (ma !== ref_mag(f == 2'd1 || f == 2'd2, a) || mb !== ref_mag(f == 2'd1, b)) begin
          errors++;
          $display("[TB] FAIL rand_mags%0d: got %h %h want %h %h", i, ma, mb,
                   ref_mag(f == 2'd1 || f == 2'd2, a), ref_mag(f == 2'd1, b));
        end
      end
    end
  endtask

  task automatic test_mul_cycles3();
    logic [31:0] a, b; logic [1:0] f; int de;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; f = 2'(i % 4);
      @(negedge clk);
      funct3 = f; op_a3 = a; op_b3 = b; req_valid3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid3 = 1'b0;
      de = 0;
      while (!resp_valid3 && de < 20) begin @(negedge clk); de++; end
      checks++;
      if (result3 !== ref_result(f, a, b) || de != 4) begin
        errors++;
        $display("[TB] FAIL cyc3_op%0d f=%0d: got %h/%0d want %h/4", i, f, result3, de, ref_result(f, a, b));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cache();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    test_mul_cycles3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
